// File: rtl/irig_pkg.sv
// Shared constants, types and helpers for the IRIG-B DCLS frame generator.
// Bit positions are frame indices, transmitted LSB (index 0) first.
package irig_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } irig_state_e;

   localparam int         FRAME_BITS = 100;
   localparam logic [6:0] LAST_BIT   = 7'd99;
   localparam logic [3:0] MS_LAST    = 4'd9;

   // High time of a bit, in ms, for a '0', a '1' and a position marker.
   localparam logic [3:0] W0 = 4'd2;
   localparam logic [3:0] W1 = 4'd5;
   localparam logic [3:0] WP = 4'd8;

   localparam int POS_SEC_U  = 1;
   localparam int POS_SEC_T  = 6;
   localparam int POS_MIN_U  = 10;
   localparam int POS_MIN_T  = 15;
   localparam int POS_HOUR_U = 20;
   localparam int POS_HOUR_T = 25;
   localparam int POS_DAY_U  = 30;
   localparam int POS_DAY_T  = 35;
   localparam int POS_DAY_H  = 40;
   localparam int POS_YEAR_U = 50;
   localparam int POS_YEAR_T = 55;
   localparam int POS_SBS_LO = 80;
   localparam int POS_SBS_HI = 90;

   localparam logic [5:0]  MAX_SEC  = 6'd60;
   localparam logic [5:0]  MAX_MIN  = 6'd59;
   localparam logic [4:0]  MAX_HOUR = 5'd23;
   localparam logic [8:0]  MIN_DAY  = 9'd1;
   localparam logic [8:0]  MAX_DAY  = 9'd366;
   localparam logic [6:0]  MAX_YEAR = 7'd99;
   localparam logic [16:0] MAX_SBS  = 17'd86400;

   typedef struct packed {
      logic [5:0]  sec;
      logic [5:0]  minute;
      logic [4:0]  hour;
      logic [8:0]  day;
      logic [6:0]  year;
      logic [16:0] sbs;
   } irig_ts_t;

   function automatic logic is_marker(logic [6:0] b);
      case (b)
         7'd0, 7'd9, 7'd19, 7'd29, 7'd39, 7'd49,
         7'd59, 7'd69, 7'd79, 7'd89, 7'd99: return 1'b1;
         default:                          return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] pulse_width(logic marker, logic val);
      if (marker) return WP;
      return val ? W1 : W0;
   endfunction

   function automatic logic ts_in_range(irig_ts_t t);
      return (t.sec <= MAX_SEC) && (t.minute <= MAX_MIN) && (t.hour <= MAX_HOUR) &&
             (t.day >= MIN_DAY) && (t.day <= MAX_DAY) && (t.year <= MAX_YEAR) &&
             (t.sbs <= MAX_SBS);
   endfunction

endpackage

// File: rtl/irig_if.sv
// Timestamp input channel of the IRIG-B encoder: binary fields plus handshake.
// A timestamp transfers on any clock edge where ts_valid and ts_ready are both 1;
// the producer holds fields and ts_valid stable until then, ts_ready never waits on ts_valid,
// and ts_err pulses one cycle after a transfer whose fields were out of range.
interface irig_if;
   logic [5:0]  ts_second;
   logic [5:0]  ts_minute;
   logic [4:0]  ts_hour;
   logic [8:0]  ts_day;
   logic [6:0]  ts_year;
   logic [16:0] ts_sec_day;
   logic        ts_valid;
   logic        ts_ready;
   logic        ts_err;

   modport master (
      output ts_second, ts_minute, ts_hour, ts_day, ts_year, ts_sec_day, ts_valid,
      input  ts_ready, ts_err
   );

   modport slave (
      input  ts_second, ts_minute, ts_hour, ts_day, ts_year, ts_sec_day, ts_valid,
      output ts_ready, ts_err
   );
endinterface

// File: rtl/irig_bcd_encoder.sv
// Combinational 9-bit binary to three BCD digits (double-dabble).
// bcd_o = {hundreds, tens, ones}.
module bcd_encoder (
   input  logic [8:0]  bin_i,
   output logic [11:0] bcd_o
);

   logic [20:0] dabble;

   always_comb begin
      dabble = {12'd0, bin_i};
      for (int i = 0; i < 9; i++) begin
         for (int d = 0; d < 3; d++) begin
            if (dabble[9 + 4*d +: 4] >= 4'd5) begin
               dabble[9 + 4*d +: 4] = dabble[9 + 4*d +: 4] + 4'd3;
            end
         end
         dabble = dabble << 1;
      end
      bcd_o = dabble[20:9];
   end

endmodule

// File: rtl/irig_encoder.sv
// IRIG-B DC level-shift frame generator: one 100-bit pulse-width-coded frame per second
// from a timestamp handed over through a one-deep shadow register.
module irig_encoder
   import irig_pkg::*;
#(
   parameter int CLKS_PER_MS = 10000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   irig_if.slave       ts,
   output logic        ts_underrun,
   output logic        irig_out,
   output logic        frame_start,
   output logic [6:0]  bit_idx,
   output irig_state_e state_dbg
);

   localparam int              SUB_W    = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CLKS_PER_MS - 1);

   irig_state_e             state_q;
   logic [SUB_W-1:0]        sub_q, sub_d;
   logic [3:0]              ms_q, ms_d;
   logic [6:0]              bit_q, bit_d;
   logic                    irig_out_q, frame_start_q, underrun_q, err_q;

   irig_ts_t                shadow_q, active_q, cap_ts, reload_ts;
   logic                    shadow_full_q;
   logic [FRAME_BITS-1:0]   frame_q, frame_d;

   logic                    sub_last, bit_last, frame_last, reload, accept;
   logic [3:0]              cur_width;
   logic [11:0]             sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd;
   logic                    unused_bcd_hi;

   assign cap_ts = {ts.ts_second, ts.ts_minute, ts.ts_hour, ts.ts_day, ts.ts_year, ts.ts_sec_day};

   assign sub_last   = (sub_q == SUB_LAST);
   assign bit_last   = sub_last && (ms_q == MS_LAST);
   assign frame_last = bit_last && (bit_q == LAST_BIT);

   // The shadow is drained in the LOAD cycle or in the final cycle of a continuing frame;
   // ts_ready is held low there so a capture never collides with the drain.
   assign reload    = (state_q == ST_LOAD) || ((state_q == ST_RUN) && frame_last && enable);
   assign accept    = ts.ts_valid && ts.ts_ready;
   assign reload_ts = shadow_full_q ? shadow_q : active_q;

   assign sub_d     = sub_q + 1'b1;
   assign ms_d      = ms_q + 4'd1;
   assign bit_d     = bit_q + 7'd1;
   assign cur_width = pulse_width(is_marker(bit_q), frame_q[bit_q]);

   bcd_encoder u_bcd_sec  (.bin_i({3'd0, reload_ts.sec}),    .bcd_o(sec_bcd));
   bcd_encoder u_bcd_min  (.bin_i({3'd0, reload_ts.minute}), .bcd_o(min_bcd));
   bcd_encoder u_bcd_hour (.bin_i({4'd0, reload_ts.hour}),   .bcd_o(hour_bcd));
   bcd_encoder u_bcd_day  (.bin_i(reload_ts.day),            .bcd_o(day_bcd));
   bcd_encoder u_bcd_year (.bin_i({2'd0, reload_ts.year}),   .bcd_o(year_bcd));

   // Upper digits are always zero for in-range fields; the frame has no slot for them.
   assign unused_bcd_hi = ^{sec_bcd[11:7], min_bcd[11:7], hour_bcd[11:6],
                            day_bcd[11:10], year_bcd[11:8]};

   always_comb begin
      frame_d = '0;
      frame_d[POS_SEC_U  +: 4] = sec_bcd[3:0];
      frame_d[POS_SEC_T  +: 3] = sec_bcd[6:4];
      frame_d[POS_MIN_U  +: 4] = min_bcd[3:0];
      frame_d[POS_MIN_T  +: 3] = min_bcd[6:4];
      frame_d[POS_HOUR_U +: 4] = hour_bcd[3:0];
      frame_d[POS_HOUR_T +: 2] = hour_bcd[5:4];
      frame_d[POS_DAY_U  +: 4] = day_bcd[3:0];
      frame_d[POS_DAY_T  +: 4] = day_bcd[7:4];
      frame_d[POS_DAY_H  +: 2] = day_bcd[9:8];
      frame_d[POS_YEAR_U +: 4] = year_bcd[3:0];
      frame_d[POS_YEAR_T +: 4] = year_bcd[7:4];
      frame_d[POS_SBS_LO +: 9] = reload_ts.sbs[8:0];
      frame_d[POS_SBS_HI +: 8] = reload_ts.sbs[16:9];
   end

   // Timestamp path: shadow capture with range check, reload into active + frame vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q      <= '0;
         shadow_full_q <= 1'b0;
         active_q      <= '0;
         frame_q       <= '0;
         err_q         <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         err_q      <= 1'b0;
         underrun_q <= 1'b0;
         if (reload) begin
            active_q      <= reload_ts;
            frame_q       <= frame_d;
            shadow_full_q <= 1'b0;
            underrun_q    <= !shadow_full_q;
         end else if (accept) begin
            if (ts_in_range(cap_ts)) begin
               shadow_q      <= cap_ts;
               shadow_full_q <= 1'b1;
            end else begin
               err_q <= 1'b1;
            end
         end
      end
   end

   // Sequencer and bit timing. Outputs are registered for the position being entered,
   // so every bit's first RUN cycle already shows the rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         sub_q         <= '0;
         ms_q          <= '0;
         bit_q         <= '0;
         irig_out_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         frame_start_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               irig_out_q <= 1'b0;
               if (enable) state_q <= ST_LOAD;
            end
            ST_LOAD: begin
               state_q       <= ST_RUN;
               sub_q         <= '0;
               ms_q          <= '0;
               bit_q         <= '0;
               irig_out_q    <= 1'b1;
               frame_start_q <= 1'b1;
            end
            ST_RUN: begin
               if (frame_last) begin
                  sub_q <= '0;
                  ms_q  <= '0;
                  bit_q <= '0;
                  if (enable) begin
                     irig_out_q    <= 1'b1;
                     frame_start_q <= 1'b1;
                  end else begin
                     irig_out_q <= 1'b0;
                     state_q    <= ST_IDLE;
                  end
               end else if (bit_last) begin
                  sub_q      <= '0;
                  ms_q       <= '0;
                  bit_q      <= bit_d;
                  irig_out_q <= 1'b1;
               end else if (sub_last) begin
                  sub_q      <= '0;
                  ms_q       <= ms_d;
                  irig_out_q <= (ms_d < cur_width);
               end else begin
                  sub_q <= sub_d;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ts.ts_ready = !shadow_full_q && !reload;
   assign ts.ts_err   = err_q;
   assign ts_underrun = underrun_q;
   assign irig_out    = irig_out_q;
   assign frame_start = frame_start_q;
   assign bit_idx     = bit_q;
   assign state_dbg   = state_q;

endmodule
